// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 multiply / 32/32 divide with HI/LO registers.
// One operation takes 34 busy cycles: PREP (operand magnitudes and signs),
// 32 CALC cycles (one radix-2 step each), FIX (sign correction, HI/LO write).
// Optional feature: define MULTDIV_DIV0_FLAG_EN to add the div0 output, which
// pulses with done when a DIV/DIVU had a zero divisor.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef MULTDIV_DIV0_FLAG_EN
  ,
  output logic        div0
`endif
);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;       // raw operands captured at start
  logic [31:0] b_mag_q;        // multiplier / divisor magnitude
  logic [63:0] acc_q;          // product accumulator; [31:0] holds dividend/quotient
  logic [31:0] rem_q;          // partial remainder (always < divisor)
  logic        neg_q;          // negate product / quotient
  logic        neg_rem_q;      // negate remainder (dividend negative)
  logic        bzero_q;        // divisor was zero

  logic        is_div, sgn;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh;
  logic [33:0] div_diff;
  logic        div_ok;
  logic [31:0] rem_next, quo_next;
  logic [63:0] prod;
  logic [31:0] quo, rem, res_hi, res_lo;

  assign is_div = op_q[1];
  assign sgn    = ~op_q[0];
  assign busy   = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: fixed PREP / 32x CALC / FIX sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PREP;
      PREP:    state_d = CALC;
      CALC:    if (cnt_q == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes, one radix-2 step for each operation, and sign fix-up.
  always_comb begin
    a_abs    = (sgn && a_q[31]) ? -a_q : a_q;
    b_abs    = (sgn && b_q[31]) ? -b_q : b_q;
    // shift-add: add multiplier into the upper half when the low bit is set
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_mag_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    // restoring divide: bring in next dividend bit, subtract if it fits
    div_sh   = {rem_q, acc_q[31]};
    div_diff = {1'b0, div_sh} - {2'b00, b_mag_q};
    div_ok   = ~div_diff[33];
    rem_next = div_ok ? div_diff[31:0] : div_sh[31:0];
    quo_next = {acc_q[30:0], div_ok};
    prod     = neg_q ? -acc_q : acc_q;
    quo      = neg_q ? -acc_q[31:0] : acc_q[31:0];
    rem      = neg_rem_q ? -rem_q : rem_q;
    if (!is_div) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (bzero_q) begin
      res_hi = a_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  // Datapath, HI/LO and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      b_mag_q   <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
`ifdef MULTDIV_DIV0_FLAG_EN
      div0      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MULTDIV_DIV0_FLAG_EN
      div0 <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // start wins over register moves issued in the same cycle
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        PREP: begin
          b_mag_q   <= b_abs;
          acc_q     <= {32'd0, a_abs};
          rem_q     <= '0;
          cnt_q     <= '0;
          neg_q     <= sgn & (a_q[31] ^ b_q[31]);
          neg_rem_q <= sgn & a_q[31];
          bzero_q   <= (b_q == 32'd0);
        end
        CALC: begin
          cnt_q <= cnt_q + 5'd1;
          if (is_div) begin
            acc_q <= {32'd0, quo_next};
            rem_q <= rem_next;
          end else begin
            acc_q <= mul_next;
          end
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
`ifdef MULTDIV_DIV0_FLAG_EN
          div0 <= is_div & bzero_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and reset.
REQ-002 The ports SHALL be:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- start  in  1  begin operation; sampled only when busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  multiplicand/dividend
- b  in  32  multiplier/divisor
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- hi  out  32  HI register
- lo  out  32  LO register
- div0  out  1  only when MULTDIV_DIV0_FLAG_EN is defined; see REQ-019

Function
REQ-003 The FSM SHALL have the states IDLE, PREP, CALC and FIX, and SHALL transition as follows:
- IDLE -> PREP on start.
- PREP -> CALC after 1 cycle.
- CALC -> FIX after exactly 32 cycles (5-bit counter).
- FIX -> IDLE after 1 cycle.
REQ-004 The block SHALL capture a, b and op at the edge where start is sampled in IDLE; later changes to these inputs SHALL NOT affect the result.
REQ-005 busy SHALL be 1 in PREP, CALC and FIX, and 0 in IDLE: 34 cycles after the start edge.
REQ-006 HI/LO SHALL update on the FIX->IDLE edge; done SHALL be 1 for exactly the following cycle (busy=0 in that cycle); start MAY be accepted in that same done cycle.
REQ-007 PREP SHALL take the absolute values of a and b for signed ops (op[0]=0) and record the result and remainder signs; unsigned ops SHALL pass operands unchanged.
REQ-008 CALC SHALL perform a radix-2 iteration per cycle: shift-add for multiply (64-bit accumulator) and restoring shift-subtract for divide (33-bit partial remainder).
REQ-009 FIX SHALL negate the results where required: product if signs differ; quotient if signs differ; remainder if the dividend is negative.
REQ-010 Multiply results SHALL be HI = product[63:32] and LO = product[31:0], exact for all 2^64 input pairs.
REQ-011 Divide results SHALL be LO = quotient and HI = remainder, with truncation toward zero and the remainder taking the sign of the dividend.
REQ-012 When b=0 on DIV or DIVU, the block SHALL write LO=0xFFFFFFFF and HI=a, using the same latency.
REQ-013 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000, with no trap.
REQ-014 mthi/mtlo SHALL write HI/LO on the next edge only when busy=0 and start=0; both high SHALL write both registers.
REQ-015 start SHALL take priority over mthi/mtlo in the same cycle, so the write is dropped.
REQ-016 start, mthi and mtlo SHALL be ignored while busy=1; there is no queueing and no error output.
REQ-017 hi and lo SHALL be direct register outputs that hold their previous values throughout an operation.

Reset
REQ-018 On reset=1 at a clock edge, the block SHALL force:
- state=IDLE, counter=0
- busy=0, done=0
- hi=0, lo=0, div0=0
- a reset mid-operation aborts the operation with no HI/LO update, and reset overrides start, mthi and mtlo.

Configuration
REQ-019 With macro MULTDIV_DIV0_FLAG_EN defined, output div0 SHALL exist; it SHALL be 1 in the done cycle of a DIV/DIVU with b=0 and 0 otherwise. When the macro is undefined, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-020 The bench SHALL cover the following scenarios:
- MULT a=0xFFFFFFFE(-2), b=0x00000003 -> after 34 busy cycles: hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse 1 cycle.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9(-7), b=0x00000002 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU 7/2 -> lo=3, hi=1.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div0=1 in the done cycle (macro on).
- mthi wdata=0xA5A5A5A5 while idle -> hi=0xA5A5A5A5 next cycle; then start MULT with mtlo=1 in the same cycle -> mtlo dropped; mthi asserted at busy cycle 10 -> ignored.
- reset asserted at CALC cycle 15 -> next cycle busy=0, hi=lo=0, no done; a new start is then accepted and completes normally.
